// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, overflow-control encodings and the holding-buffer entry
// layout for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;
  localparam int NREQ      = 3;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [1:0] OFC_NONE = 2'b00;
  localparam logic [1:0] OFC_CLR  = 2'b10;
  localparam logic [1:0] OFC_SET  = 2'b11;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
    logic [1:0]           ovf;
  } wb_entry_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_picker.sv
// Combinational grant selection: same-register age filter, then round-robin
// over the surviving occupied buffers starting at ptr.
module wb_grant_picker
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N = regfile_wb_arbiter_pkg::NREQ,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]                occ,
  input  logic [N-1:0][REG_IDX_W-1:0] regs,
  input  logic [N-1:0][N-1:0]         older,
  input  logic [PW-1:0]               ptr,
  output logic                        gnt_vld,
  output logic [PW-1:0]               gnt_idx,
  output logic [N-1:0]                gnt
);
  logic [N-1:0] elig;

  // older[j][i] set means buffer j arrived before buffer i
  always_comb begin
    elig = occ;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (j != i && occ[j] && regs[j] == regs[i] && older[j][i])
          elig[i] = 1'b0;
  end

  always_comb begin
    logic [PW:0] sum;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      if (!gnt_vld && elig[sum[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: one holding buffer per requester, in-order per
// destination register, round-robin across registers, one write per clock.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = regfile_wb_arbiter_pkg::NREQ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0][REG_IDX_W-1:0] req_reg,
  input  logic [NREQ-1:0][DATA_W-1:0]    req_data,
  input  logic [NREQ-1:0][1:0]           req_ovf,
  output logic                           regwrite,
  output logic [REG_IDX_W-1:0]           wrreg,
  output logic [DATA_W-1:0]              wrdata,
  output logic [1:0]                     of_control,
  output logic [(1<<REG_IDX_W)-1:0]      pend_mask
);
  localparam int PW = ptr_w(NREQ);

  wb_entry_t [NREQ-1:0]           ent;
  logic [NREQ-1:0]                occ;
  logic [NREQ-1:0][NREQ-1:0]      older;
  logic [NREQ-1:0][REG_IDX_W-1:0] ent_rd;
  logic [PW-1:0]                  ptr;
  logic [PW-1:0]                  gnt_idx;
  logic                           gnt_vld;
  logic [NREQ-1:0]                gnt;
  logic [NREQ-1:0]                arrive;
  wb_entry_t                      g_ent;

  // Ready never looks at req_valid, so no loop through the requester.
  assign req_ready = ~occ | gnt;
  assign arrive    = req_valid & req_ready;
  assign g_ent     = ent[gnt_idx];

  always_comb begin
    for (int i = 0; i < NREQ; i++) ent_rd[i] = ent[i].rd;
  end

  wb_grant_picker #(.N(NREQ)) u_picker (
    .occ     (occ),
    .regs    (ent_rd),
    .older   (older),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ   <= '0;
      ent   <= '0;
      older <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (arrive[i]) begin
          occ[i] <= 1'b1;
          ent[i] <= '{rd: req_reg[i], data: req_data[i], ovf: req_ovf[i]};
        end else if (gnt[i]) begin
          occ[i] <= 1'b0;
        end
      end
      // A new arrival is younger than everything held; simultaneous arrivals
      // order by index. Bits for empty buffers are don't-care.
      for (int i = 0; i < NREQ; i++)
        for (int j = 0; j < NREQ; j++)
          if (i != j) begin
            if (arrive[i] && arrive[j]) older[i][j] <= (i < j);
            else if (arrive[i])         older[i][j] <= 1'b0;
            else if (arrive[j])         older[i][j] <= 1'b1;
          end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      regwrite   <= 1'b0;
      wrreg      <= '0;
      wrdata     <= '0;
      of_control <= OFC_NONE;
    end else if (gnt_vld) begin
      ptr        <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      regwrite   <= |g_ent.rd;
      wrreg      <= g_ent.rd;
      wrdata     <= g_ent.data;
      of_control <= (|g_ent.rd) ? g_ent.ovf : OFC_NONE;
    end else begin
      regwrite   <= 1'b0;
      of_control <= OFC_NONE;
    end
  end

  // regwrite is low for $0 writes, so it doubles as the output-stage valid here.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NREQ; i++)
      if (occ[i]) pend_mask[ent[i].rd] = 1'b1;
    if (regwrite) pend_mask[wrreg] = 1'b1;
    pend_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against an arrival-stamp model of
// the write-back arbiter.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;
  localparam int N = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][4:0]     req_reg;
  logic [N-1:0][31:0]    req_data;
  logic [N-1:0][1:0]     req_ovf;
  logic                  regwrite;
  logic [4:0]            wrreg;
  logic [31:0]           wrdata;
  logic [1:0]            of_control;
  logic [31:0]           pend_mask;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data), .req_ovf(req_ovf),
    .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata),
    .of_control(of_control), .pend_mask(pend_mask)
  );

  // reference model: each buffer carries a global arrival stamp
  bit          m_vld[N];
  logic [4:0]  m_reg[N];
  logic [31:0] m_data[N];
  logic [1:0]  m_ovf[N];
  int          m_seq[N];
  int          seq_ctr, m_ptr;
  logic        e_rw;
  logic [4:0]  e_wrreg;
  logic [31:0] e_wrdata;
  logic [1:0]  e_ofc;

  task automatic mdl_reset();
    for (int i = 0; i < N; i++) begin m_vld[i] = 0; m_seq[i] = 0; end
    seq_ctr = 0; m_ptr = 0;
    e_rw = 0; e_wrreg = 0; e_wrdata = 0; e_ofc = 0;
  endtask

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      bit blocked = 0;
      if (m_vld[i]) begin
        for (int j = 0; j < N; j++)
          if (j != i && m_vld[j] && m_reg[j] == m_reg[i] && m_seq[j] < m_seq[i])
            blocked = 1;
        if (!blocked) return i;
      end
    end
    return -1;
  endfunction

  task automatic clr_req();
    req_valid = '0; req_reg = '0; req_data = '0; req_ovf = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d,
                         input logic [1:0] o);
    req_valid[i] = 1'b1; req_reg[i] = r; req_data[i] = d; req_ovf[i] = o;
  endtask

  task automatic pos();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    clr_req();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    mdl_reset();
  endtask

  task automatic test_reset();
    clr_req();
    @(negedge clk); rst = 1'b0; #1;
    chk_cnt++;
    if ({regwrite, wrreg, wrdata, of_control, pend_mask} !== '0)
      $display("FAIL reset_outputs: got rw=%0b reg=%0d data=%h ofc=%b pend=%h want all 0",
               regwrite, wrreg, wrdata, of_control, pend_mask);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 3'b111) $display("FAIL reset_ready: got %b want 111", req_ready);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    mdl_reset();
    for (int c = 0; c < 3; c++) begin
      pos();
      chk_cnt++;
      if (regwrite !== 1'b0) $display("FAIL reset_idle_rw: got %b want 0", regwrite);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk); set_req(0, 5'd5, 32'h1234, 2'b00);
    pos();
    chk_cnt++;
    if (regwrite !== 1'b0 || pend_mask !== 32'h20)
      $display("FAIL single_buffered: got rw=%b pend=%h want rw=0 pend=00000020", regwrite, pend_mask);
    else pass_cnt++;
    @(negedge clk); clr_req();
    pos();
    chk_cnt++;
    if ({regwrite, wrreg, wrdata, of_control, pend_mask} !== {1'b1, 5'd5, 32'h1234, 2'b00, 32'h20})
      $display("FAIL single_commit: got rw=%b reg=%0d data=%h ofc=%b pend=%h want 1 5 00001234 00 00000020",
               regwrite, wrreg, wrdata, of_control, pend_mask);
    else pass_cnt++;
    pos();
    chk_cnt++;
    if ({regwrite, wrreg, wrdata, pend_mask} !== {1'b0, 5'd5, 32'h1234, 32'h0})
      $display("FAIL single_after: got rw=%b reg=%0d data=%h pend=%h want 0 5 00001234 0",
               regwrite, wrreg, wrdata, pend_mask);
    else pass_cnt++;
  endtask

  task automatic test_rr();
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      logic [31:0] base = 32'h100 * (rep + 1);
      @(negedge clk);
      set_req(0, 5'd3, base, 2'b00);
      set_req(1, 5'd4, base + 1, 2'b00);
      set_req(2, 5'd6, base + 2, 2'b00);
      pos();
      @(negedge clk); clr_req();
      for (int k = 0; k < 3; k++) begin
        pos();
        chk_cnt++;
        if (regwrite !== 1'b1 || wrdata !== base + 32'(k))
          $display("FAIL rr_order rep%0d slot%0d: got rw=%b data=%h want 1 %h",
                   rep, k, regwrite, wrdata, base + 32'(k));
        else pass_cnt++;
      end
      pos();
      chk_cnt++;
      if (regwrite !== 1'b0) $display("FAIL rr_drain rep%0d: got rw=%b want 0", rep, regwrite);
      else pass_cnt++;
    end
  endtask

  task automatic test_order();
    logic [31:0] q[$];
    apply_reset();
    @(negedge clk);
    set_req(0, 5'd11, 32'h11, 2'b00);
    set_req(1, 5'd10, 32'h10, 2'b00);
    set_req(2, 5'd7,  32'hA,  2'b00);
    pos();
    @(negedge clk); clr_req(); set_req(0, 5'd7, 32'hB, 2'b00); #1;
    chk_cnt++;
    if (req_ready !== 3'b001) $display("FAIL order_refill_ready: got %b want 001", req_ready);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      pos();
      if (regwrite) q.push_back(wrdata);
      if (k == 0) begin @(negedge clk); clr_req(); end
    end
    chk_cnt++;
    if (q.size() != 4 || q[0] !== 32'h11 || q[1] !== 32'h10 || q[2] !== 32'hA || q[3] !== 32'hB)
      $display("FAIL order_seq: got %0d commits %p want 11 10 a b", q.size(), q);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    apply_reset();
    @(negedge clk); set_req(0, 5'd0, 32'hDEAD, 2'b11);
    pos();
    chk_cnt++;
    if (pend_mask !== 32'h0) $display("FAIL zero_pend_buf: got %h want 0", pend_mask);
    else pass_cnt++;
    @(negedge clk); clr_req();
    pos();
    chk_cnt++;
    if (regwrite !== 1'b0 || of_control !== 2'b00 || pend_mask !== 32'h0)
      $display("FAIL zero_commit: got rw=%b ofc=%b pend=%h want 0 00 0", regwrite, of_control, pend_mask);
    else pass_cnt++;
  endtask

  task automatic test_ovf();
    logic [1:0] ov[2] = '{2'b11, 2'b10};
    apply_reset();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); set_req(0, 5'd8, 32'h55 + 32'(t), ov[t]);
      pos();
      @(negedge clk); clr_req();
      pos();
      chk_cnt++;
      if (regwrite !== 1'b1 || wrreg !== 5'd8 || of_control !== ov[t])
        $display("FAIL ovf_commit%0d: got rw=%b reg=%0d ofc=%b want 1 8 %b",
                 t, regwrite, wrreg, of_control, ov[t]);
      else pass_cnt++;
    end
    pos();
    chk_cnt++;
    if (regwrite !== 1'b0 || of_control !== 2'b00)
      $display("FAIL ovf_idle: got rw=%b ofc=%b want 0 00", regwrite, of_control);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit pulse = 0;
    apply_reset();
    @(negedge clk);
    set_req(0, 5'd12, 32'h1, 2'b11);
    set_req(1, 5'd13, 32'h2, 2'b10);
    set_req(2, 5'd14, 32'h3, 2'b11);
    pos();
    pos();
    @(negedge clk); clr_req(); rst = 1'b0; #1;
    chk_cnt++;
    if ({regwrite, wrreg, wrdata, of_control, pend_mask} !== '0 || req_ready !== 3'b111)
      $display("FAIL midreset_outputs: got rw=%b reg=%0d data=%h ofc=%b pend=%h rdy=%b want zeros rdy=111",
               regwrite, wrreg, wrdata, of_control, pend_mask, req_ready);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    mdl_reset();
    for (int c = 0; c < 6; c++) begin
      pos();
      if (regwrite || pend_mask != 0) pulse = 1;
    end
    chk_cnt++;
    if (pulse) $display("FAIL midreset_no_pulse: got pulse=1 want 0");
    else pass_cnt++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [N-1:0] e_rdy;
      logic [31:0]  e_pend;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 55);
        req_reg[i]   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        req_data[i]  = $urandom;
        req_ovf[i]   = 2'($urandom);
      end
      #1;
      g = m_pick();
      for (int i = 0; i < N; i++) e_rdy[i] = !m_vld[i] || (g == i);
      chk_cnt++;
      if (req_ready !== e_rdy) $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, e_rdy);
      else pass_cnt++;
      @(posedge clk);
      if (g >= 0) begin
        e_rw     = (m_reg[g] != 0);
        e_wrreg  = m_reg[g];
        e_wrdata = m_data[g];
        e_ofc    = (m_reg[g] != 0) ? m_ovf[g] : 2'b00;
        m_ptr    = (g + 1) % N;
        m_vld[g] = 0;
      end else begin
        e_rw = 0; e_ofc = 2'b00;
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && e_rdy[i]) begin
          m_vld[i] = 1; m_reg[i] = req_reg[i]; m_data[i] = req_data[i];
          m_ovf[i] = req_ovf[i]; m_seq[i] = seq_ctr++;
        end
      #1;
      e_pend = 0;
      for (int i = 0; i < N; i++) if (m_vld[i]) e_pend[m_reg[i]] = 1'b1;
      if (e_rw) e_pend[e_wrreg] = 1'b1;
      e_pend[0] = 1'b0;
      chk_cnt++;
      if ({regwrite, wrreg, wrdata, of_control, pend_mask} !== {e_rw, e_wrreg, e_wrdata, e_ofc, e_pend})
        $display("FAIL rand_out c%0d: got rw=%b reg=%0d data=%h ofc=%b pend=%h want %b %0d %h %b %h",
                 c, regwrite, wrreg, wrdata, of_control, pend_mask,
                 e_rw, e_wrreg, e_wrdata, e_ofc, e_pend);
      else pass_cnt++;
    end
    @(negedge clk); clr_req();
  endtask

  initial begin
    clr_req();
    mdl_reset();
    test_reset();
    test_single();
    test_rr();
    test_order();
    test_zero_reg();
    test_ovf();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
